// File: rtl/addsub_bcd_seq_ctrl.sv
// addsub_bcd_seq_ctrl: debounced GO button starts one add/subtract of the
// switch operands; the signed result is converted to sign + 3 BCD digits by a
// double-dabble loop (one iteration per cycle). The outputs hold the last
// completed result for the display mux until the next completion.
module addsub_bcd_seq_ctrl #(
    parameter int DEB_CYCLES = 50000,
    parameter int DW         = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] SW_A,
    input  logic [DW-1:0] SW_B,
    input  logic          KEY_OP,
    input  logic          KEY_GO,
    output logic          BUSY,
    output logic          DONE,
    output logic          SIGN,
    output logic [11:0]   BCD
);

    localparam int CW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RW  = DW + 2;   // signed sum/difference width
    localparam int MW  = DW + 1;   // magnitude width (0..510)
    localparam int SHW = 12 + MW;  // BCD digits above the binary magnitude

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [3:0]    ITER_LAST = 4'(MW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_COMPUTE,
        S_CONVERT
    } state_t;

    // Button synchronizer and debouncer state.
    logic          sync1_q, sync2_q;
    logic          deb_lvl_q, deb_lvl_d;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic          accept;

    // Sequencer state.
    state_t         state_q, state_d;
    logic [DW-1:0]  a_q, a_d, b_q, b_d;
    logic           op_q, op_d;
    logic [SHW-1:0] shift_q, shift_d;
    logic [3:0]     iter_q, iter_d;
    logic           neg_q, neg_d;
    logic [11:0]    bcd_q, bcd_d;
    logic           sign_q, sign_d;
    logic           done_q, done_d;

    // Arithmetic on the captured operands.
    logic [RW-1:0]  res;
    logic           res_neg;
    logic [RW-1:0]  res_mag;
    logic [SHW-1:0] shift_adj;

    // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
    function automatic logic [SHW-1:0] add3(input logic [SHW-1:0] s);
        logic [SHW-1:0] r;
        r = s;
        for (int d = 0; d < 3; d++) begin
            if (r[MW + 4*d +: 4] >= 4'd5)
                r[MW + 4*d +: 4] = r[MW + 4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign res       = op_q ? ({2'b00, a_q} - {2'b00, b_q}) : ({2'b00, a_q} + {2'b00, b_q});
    assign res_neg   = res[RW-1] & (res != '0);
    assign res_mag   = res_neg ? -res : res;
    assign shift_adj = add3(shift_q);

    // Debounce: flip the accepted level after DEB_CYCLES consecutive cycles of
    // disagreement; a rising flip is the accept pulse.
    always_comb begin
        deb_cnt_d = '0;
        deb_lvl_d = deb_lvl_q;
        accept    = 1'b0;
        if (sync2_q != deb_lvl_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_lvl_d = sync2_q;
                accept    = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Next-state and datapath control for IDLE -> CAPTURE -> COMPUTE -> CONVERT.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        neg_d   = neg_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                a_d     = SW_A;
                b_d     = SW_B;
                op_d    = KEY_OP;
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                neg_d   = res_neg;
                shift_d = {{(SHW-RW){1'b0}}, res_mag};
                iter_d  = '0;
                state_d = S_CONVERT;
            end
            S_CONVERT: begin
                shift_d = shift_adj << 1;
                iter_d  = iter_q + 4'd1;
                if (iter_q == ITER_LAST) begin
                    bcd_d   = shift_d[SHW-1:MW];
                    sign_d  = neg_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any operation in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_lvl_q <= 1'b0;
            deb_cnt_q <= '0;
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            shift_q   <= '0;
            iter_q    <= '0;
            neg_q     <= 1'b0;
            bcd_q     <= '0;
            sign_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so the two synchronizer stages
            // each add one register delay instead of collapsing into a wire.
            sync1_q   <= KEY_GO;
            sync2_q   <= sync1_q;
            deb_lvl_q <= deb_lvl_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            shift_q   <= shift_d;
            iter_q    <= iter_d;
            neg_q     <= neg_d;
            bcd_q     <= bcd_d;
            sign_q    <= sign_d;
            done_q    <= done_d;
        end
    end

    assign BUSY = (state_q != S_IDLE);
    assign DONE = done_q;
    assign SIGN = sign_q;
    assign BCD  = bcd_q;

endmodule
